mc_controller: RTL and testbench

- Multicycle main controller FSM for the MIPS core.
- Sequences a shared-memory datapath (single memory port for fetch and data) through fetch, decode, execute, memory and writeback steps.
- Emits per-state datapath selects, a memory request/ready handshake and the qualified PC enable.
- Sits beside the datapath and replaces the single-cycle combinational controller when the core runs from one unified memory.

---
 rtl/mc_pkg.sv | 52 +++++
 rtl/mc_controller_if.sv | 34 +++
 rtl/mc_alu_dec.sv | 35 +++
 rtl/mc_controller.sv | 235 +++++++++++++++++++++++
 tb/tb_mc_controller.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath/memory bundle: decoded instruction fields in, selects and handshake out.
interface mc_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alucontrol;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;

    modport ctrl (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_write, iord, ir_write, pc_en, pc_src,
               alu_src_a, alu_src_b, alucontrol, reg_dst, mem_to_reg,
               reg_write, illegal
    );

    modport dp (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_write, iord, ir_write, pc_en, pc_src,
               alu_src_a, alu_src_b, alucontrol, reg_dst, mem_to_reg,
               reg_write, illegal
    );
endinterface

// File: rtl/mc_alu_dec.sv
// ALU decoder: maps the controller's alu_op and the R-type funct field to alucontrol.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       funct_illegal
);

    // Unsupported funct codes yield alucontrol 000 and raise funct_illegal.
    always_comb begin
        alucontrol    = ALU_ADD;
        funct_illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: begin
                        alucontrol    = 3'b000;
                        funct_illegal = 1'b1;
                    end
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle main controller for the unified-memory MIPS core.
// Optional build macro MC_PERF_CNT_EN adds cycle_cnt/instr_cnt performance counters.
module mc_controller
    import mc_pkg::*;
#(
    parameter int unsigned RESET_PC_HOLD = 0
) (
    input  logic         clk,
    input  logic         rst,
    mc_controller_if.ctrl bus
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]  cycle_cnt,
    output logic [31:0]  instr_cnt
`endif
);

    localparam logic [3:0] HOLD_INIT = 4'(RESET_PC_HOLD);

    state_t     state_r;
    state_t     state_next_s;
    logic [3:0] hold_r;
    logic       run_r;

    logic       mem_req_s;
    logic       mem_write_s;
    logic       iord_s;
    logic       ir_write_s;
    logic       pc_en_s;
    logic [1:0] pc_src_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic       alu_use_s;
    logic       reg_dst_s;
    logic       mem_to_reg_s;
    logic       reg_write_s;
    logic       illegal_s;
    logic [2:0] dec_alucontrol_s;
    logic       funct_illegal_s;

    mc_alu_dec u_alu_dec (
        .alu_op        (alu_op_s),
        .funct         (bus.funct),
        .alucontrol    (dec_alucontrol_s),
        .funct_illegal (funct_illegal_s)
    );

    // State register plus post-reset hold counter gating the first fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_FETCH;
            hold_r  <= HOLD_INIT;
            run_r   <= 1'b0;
        end else if (!run_r) begin
            if (hold_r == 4'd0) begin
                run_r <= 1'b1;
            end else begin
                hold_r <= hold_r - 4'd1;
            end
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and per-state datapath controls; everything idles low until run.
    always_comb begin
        state_next_s = state_r;
        mem_req_s    = 1'b0;
        mem_write_s  = 1'b0;
        iord_s       = 1'b0;
        ir_write_s   = 1'b0;
        pc_en_s      = 1'b0;
        pc_src_s     = PCSRC_ALU;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = SRCB_RT;
        alu_op_s     = ALUOP_ADD;
        alu_use_s    = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        illegal_s    = 1'b0;
        if (run_r) begin
            case (state_r)
                S_FETCH: begin
                    mem_req_s   = 1'b1;
                    alu_src_b_s = SRCB_FOUR;
                    alu_use_s   = 1'b1;
                    if (bus.mem_ready) begin
                        ir_write_s   = 1'b1;
                        pc_en_s      = 1'b1;
                        state_next_s = S_DECODE;
                    end else begin
                        state_next_s = S_FETCH;
                    end
                end
                S_DECODE: begin
                    alu_src_b_s = SRCB_IMM_SH2;
                    alu_use_s   = 1'b1;
                    case (bus.opcode)
                        OP_LW, OP_SW:   state_next_s = S_MEMADR;
                        OP_RTYPE:       state_next_s = S_EXEC;
                        OP_BEQ, OP_BNE: state_next_s = S_BRANCH;
                        OP_ADDI:        state_next_s = S_ADDIEX;
                        OP_J:           state_next_s = S_JUMP;
                        default: begin
                            illegal_s    = 1'b1;
                            state_next_s = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a_s = 1'b1;
                    alu_src_b_s = SRCB_IMM;
                    alu_use_s   = 1'b1;
                    if (bus.opcode == OP_SW) begin
                        state_next_s = S_MEMWR;
                    end else begin
                        state_next_s = S_MEMRD;
                    end
                end
                S_MEMRD: begin
                    mem_req_s = 1'b1;
                    iord_s    = 1'b1;
                    if (bus.mem_ready) begin
                        state_next_s = S_MEMWB;
                    end else begin
                        state_next_s = S_MEMRD;
                    end
                end
                S_MEMWB: begin
                    mem_to_reg_s = 1'b1;
                    reg_write_s  = 1'b1;
                    state_next_s = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req_s   = 1'b1;
                    mem_write_s = 1'b1;
                    iord_s      = 1'b1;
                    if (bus.mem_ready) begin
                        state_next_s = S_FETCH;
                    end else begin
                        state_next_s = S_MEMWR;
                    end
                end
                S_EXEC: begin
                    alu_src_a_s = 1'b1;
                    alu_op_s    = ALUOP_FUNCT;
                    alu_use_s   = 1'b1;
                    if (funct_illegal_s) begin
                        illegal_s    = 1'b1;
                        state_next_s = S_FETCH;
                    end else begin
                        state_next_s = S_ALUWB;
                    end
                end
                S_ALUWB: begin
                    reg_dst_s    = 1'b1;
                    reg_write_s  = 1'b1;
                    state_next_s = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a_s  = 1'b1;
                    alu_op_s     = ALUOP_SUB;
                    alu_use_s    = 1'b1;
                    pc_src_s     = PCSRC_ALUOUT;
                    pc_en_s      = ((bus.opcode == OP_BEQ) &&  bus.zero) ||
                                   ((bus.opcode == OP_BNE) && !bus.zero);
                    state_next_s = S_FETCH;
                end
                S_ADDIEX: begin
                    alu_src_a_s  = 1'b1;
                    alu_src_b_s  = SRCB_IMM;
                    alu_use_s    = 1'b1;
                    state_next_s = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_write_s  = 1'b1;
                    state_next_s = S_FETCH;
                end
                S_JUMP: begin
                    pc_src_s     = PCSRC_JUMP;
                    pc_en_s      = 1'b1;
                    state_next_s = S_FETCH;
                end
                default: state_next_s = S_FETCH;
            endcase
        end else begin
            state_next_s = S_FETCH;
        end
    end

    assign bus.mem_req    = mem_req_s;
    assign bus.mem_write  = mem_write_s;
    assign bus.iord       = iord_s;
    assign bus.ir_write   = ir_write_s;
    assign bus.pc_en      = pc_en_s;
    assign bus.pc_src     = pc_src_s;
    assign bus.alu_src_a  = alu_src_a_s;
    assign bus.alu_src_b  = alu_src_b_s;
    assign bus.alucontrol = alu_use_s ? dec_alucontrol_s : 3'b000;
    assign bus.reg_dst    = reg_dst_s;
    assign bus.mem_to_reg = mem_to_reg_s;
    assign bus.reg_write  = reg_write_s;
    assign bus.illegal    = illegal_s;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt_r;
    logic [31:0] instr_cnt_r;
    logic        instr_done_s;

    // An instruction retires when a non-fetch state hands back to FETCH without faulting.
    assign instr_done_s = run_r && (state_r != S_FETCH) &&
                          (state_next_s == S_FETCH) && !illegal_s;

    // Free-running performance counters, wrapping naturally at 32 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_r <= 32'd0;
            instr_cnt_r <= 32'd0;
        end else begin
            if (run_r) begin
                cycle_cnt_r <= cycle_cnt_r + 32'd1;
            end
            if (instr_done_s) begin
                instr_cnt_r <= instr_cnt_r + 32'd1;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_r;
    assign instr_cnt = instr_cnt_r;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-cycle control-word model plus directed checks.
module tb_mc_controller;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alucontrol;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal;
    } ctl_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        ctl_t       exp;
    } rec_t;

    logic clk;
    logic rst;
    mc_controller_if bus();

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
`endif

    mc_controller #(.RESET_PC_HOLD(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total;
    int   bad;
    int   exp_instr;
    rec_t q[$];
    ctl_t cur;
    logic cur_valid;
    ctl_t act_w;

    function automatic ctl_t dut_ctl();
        ctl_t c;
        c.mem_req    = bus.mem_req;
        c.mem_write  = bus.mem_write;
        c.iord       = bus.iord;
        c.ir_write   = bus.ir_write;
        c.pc_en      = bus.pc_en;
        c.pc_src     = bus.pc_src;
        c.alu_src_a  = bus.alu_src_a;
        c.alu_src_b  = bus.alu_src_b;
        c.alucontrol = bus.alucontrol;
        c.reg_dst    = bus.reg_dst;
        c.mem_to_reg = bus.mem_to_reg;
        c.reg_write  = bus.reg_write;
        c.illegal    = bus.illegal;
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Reference: R-type funct -> ALU code; unknown funct gives 000 and is illegal.
    function automatic logic [3:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h2A:   return 4'b0111;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input logic rdy, input ctl_t c);
        rec_t r;
        r.op = op; r.fn = fn; r.z = z; r.rdy = rdy; r.exp = c;
        q.push_back(r);
    endtask

    // Expand one instruction into its expected cycle-by-cycle control words.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int fw, input int mw);
        ctl_t c;
        logic legal;
        logic [3:0] ra;
        for (int i = 0; i <= fw; i++) begin
            c = '0; c.mem_req = 1'b1; c.alu_src_b = 2'b01; c.alucontrol = 3'b010;
            c.ir_write = (i == fw); c.pc_en = (i == fw);
            push(op, fn, z, (i == fw), c);
        end
        legal = (op == 6'h23) || (op == 6'h2B) || (op == 6'h00) || (op == 6'h04) ||
                (op == 6'h05) || (op == 6'h08) || (op == 6'h02);
        c = '0; c.alu_src_b = 2'b11; c.alucontrol = 3'b010; c.illegal = !legal;
        push(op, fn, z, 1'b1, c);
        if (!legal) return;
        if (op == 6'h23 || op == 6'h2B) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alucontrol = 3'b010;
            push(op, fn, z, 1'b1, c);
            for (int i = 0; i <= mw; i++) begin
                c = '0; c.mem_req = 1'b1; c.iord = 1'b1; c.mem_write = (op == 6'h2B);
                push(op, fn, z, (i == mw), c);
            end
            if (op == 6'h23) begin
                c = '0; c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
                push(op, fn, z, 1'b1, c);
            end
        end else if (op == 6'h00) begin
            ra = r_alu(fn);
            c = '0; c.alu_src_a = 1'b1; c.alucontrol = ra[2:0]; c.illegal = ra[3];
            push(op, fn, z, 1'b1, c);
            if (ra[3]) return;
            c = '0; c.reg_dst = 1'b1; c.reg_write = 1'b1;
            push(op, fn, z, 1'b1, c);
        end else if (op == 6'h04 || op == 6'h05) begin
            c = '0; c.alu_src_a = 1'b1; c.alucontrol = 3'b110; c.pc_src = 2'b01;
            c.pc_en = (op == 6'h04) ? z : !z;
            push(op, fn, z, 1'b1, c);
        end else if (op == 6'h08) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alucontrol = 3'b010;
            push(op, fn, z, 1'b1, c);
            c = '0; c.reg_write = 1'b1;
            push(op, fn, z, 1'b1, c);
        end else begin
            c = '0; c.pc_src = 2'b10; c.pc_en = 1'b1;
            push(op, fn, z, 1'b1, c);
        end
        exp_instr++;
    endtask

    // Apply up to n queued cycles, one per clock, publishing the expectation.
    task automatic run_prog(input int n);
        rec_t r;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            r = q.pop_front();
            @(posedge clk); #1;
            bus.opcode = r.op; bus.funct = r.fn; bus.zero = r.z; bus.mem_ready = r.rdy;
            cur = r.exp; cur_valid = 1'b1;
        end
        @(negedge clk); #1;
        cur_valid = 1'b0;
    endtask

    // Per-cycle comparison of the whole control word against the model.
    always @(negedge clk) begin
        if (cur_valid) begin
            act_w = dut_ctl();
            total++;
            if (act_w !== cur) begin
                bad++;
                $display("FAIL ctl_word t=%0t act=%h exp=%h", $time, act_w, cur);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; exp_instr = 0; cur_valid = 1'b0; cur = '0;
        rst = 1'b0;
        bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("reset_outs", 32'(dut_ctl()), 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1 chk("hold_cyc1", 32'(dut_ctl()), 32'd0);
        @(posedge clk); #1 chk("hold_cyc2", 32'(dut_ctl()), 32'd0);

        // First fetch lands on the third edge after release.
        build(6'h00, 6'h20, 1'b0, 0, 0);
        chk("model_rtype_len", 32'(q.size()), 32'd4);
        chk("model_rtype_wb", {30'd0, q[3].exp.reg_write, q[3].exp.reg_dst}, 32'd3);
        run_prog(q.size());

        build(6'h00, 6'h22, 1'b0, 0, 0);
        build(6'h00, 6'h24, 1'b1, 0, 0);
        build(6'h00, 6'h25, 1'b0, 0, 0);
        build(6'h00, 6'h2A, 1'b0, 0, 0);
        run_prog(q.size());

        build(6'h23, 6'h00, 1'b0, 0, 2);
        chk("model_lw_len", 32'(q.size()), 32'd7);
        chk("model_lw_wb", {30'd0, q[6].exp.mem_to_reg, q[6].exp.reg_write}, 32'd3);
        run_prog(q.size());

        build(6'h2B, 6'h00, 1'b0, 1, 1);
        run_prog(q.size());

        build(6'h04, 6'h00, 1'b1, 0, 0);
        chk("model_beq_len", 32'(q.size()), 32'd3);
        chk("model_beq_taken", {30'd0, q[2].exp.pc_src}, 32'd1);
        build(6'h04, 6'h00, 1'b0, 0, 0);
        build(6'h05, 6'h00, 1'b1, 0, 0);
        chk("model_bne_z1", {31'd0, q[8].exp.pc_en}, 32'd0);
        build(6'h05, 6'h00, 1'b0, 0, 0);
        run_prog(q.size());

        build(6'h08, 6'h00, 1'b0, 0, 0);
        build(6'h02, 6'h00, 1'b0, 2, 0);
        run_prog(q.size());

        build(6'h3F, 6'h00, 1'b0, 0, 0);
        chk("model_illegal_op", {30'd0, q[1].exp.illegal, q.size() == 2}, 32'd3);
        build(6'h00, 6'h3F, 1'b0, 0, 0);
        run_prog(q.size());

`ifdef MC_PERF_CNT_EN
        chk("instr_cnt", instr_cnt, 32'(exp_instr));
`endif

        // Abort a store mid-access with an asynchronous reset.
        build(6'h2B, 6'h00, 1'b0, 0, 3);
        run_prog(4);
        q.delete();
        chk("pre_abort_memwr", {30'd0, bus.mem_req, bus.mem_write}, 32'd3);
        rst = 1'b0;
        #1 chk("abort_async", 32'(dut_ctl()), 32'd0);
`ifdef MC_PERF_CNT_EN
        chk("abort_cycle_cnt", cycle_cnt, 32'd0);
        chk("abort_instr_cnt", instr_cnt, 32'd0);
`endif
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1 chk("rehold_cyc1", 32'(dut_ctl()), 32'd0);
        @(posedge clk); #1 chk("rehold_cyc2", 32'(dut_ctl()), 32'd0);
        build(6'h00, 6'h20, 1'b0, 0, 0);
        run_prog(q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
